// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator command sequencer.
package rpn_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned BTN_W  = 3;

    localparam logic [OP_W-1:0] OP_PUSH = 2'd0;
    localparam logic [OP_W-1:0] OP_POP  = 2'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 2'd2;
    localparam logic [OP_W-1:0] OP_MULT = 2'd3;

    localparam int unsigned BTN_POP  = 2;
    localparam int unsigned BTN_ADD  = 1;
    localparam int unsigned BTN_MULT = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // One-hot Btns pattern for a non-PUSH op; PUSH maps to no button.
    function automatic logic [BTN_W-1:0] op_to_btns(input logic [OP_W-1:0] op);
        logic [BTN_W-1:0] b;
        b = '0;
        case (op)
            OP_POP:  b[BTN_POP]  = 1'b1;
            OP_ADD:  b[BTN_ADD]  = 1'b1;
            OP_MULT: b[BTN_MULT] = 1'b1;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rpn_cmd_fifo.sv
// Synchronous command FIFO holding {op,data}; writes are refused while full.
module rpn_cmd_fifo
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         wr_en,
    input  cmd_t                         wr_data,
    input  logic                         rd_en,
    output cmd_t                         rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    // Pointer widths equal log2(DEPTH), so wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/rpn_cmd_sequencer.sv
// Replays queued calculator commands onto the RPN CPU as timed strobes and
// captures CPU results on each rising Dval edge.
module rpn_cmd_sequencer
    import rpn_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 50
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [7:0]                   cmd_data,
    output logic [7:0]                   Din,
    output logic                         Sample,
    output logic [2:0]                   Btns,
    input  logic                         cpu_dval,
    input  logic [7:0]                   cpu_dout,
    output logic                         res_valid,
    output logic [7:0]                   res_data,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    // Async assert, sync release of the internal reset.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    cmd_t             wr_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             rd_en;

    assign wr_cmd = '{op: cmd_op, data: cmd_data};

    rpn_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .Reset   (rst_int),
        .wr_en   (cmd_valid),
        .wr_data (wr_cmd),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       din_q, din_d;
    logic             sample_q, sample_d;
    logic [2:0]       btns_q, btns_d;
    logic             dval_q, dval_d;
    logic             dval_dly_q, dval_dly_d;
    logic [7:0]       dout_q, dout_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;

    // Issue / pulse / gap sequencing; strobes default low so GAP needs no clears.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        sample_d = 1'b0;
        btns_d   = '0;
        rd_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    rd_en = 1'b1;
                    if (head.op == OP_PUSH) begin
                        din_d    = head.data;
                        sample_d = 1'b1;
                    end else begin
                        btns_d = op_to_btns(head.op);
                    end
                    cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    sample_d = sample_q;
                    btns_d   = btns_q;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result capture runs regardless of FSM state.
    always_comb begin
        dval_d      = cpu_dval;
        dout_d      = cpu_dout;
        dval_dly_d  = dval_q;
        res_valid_d = dval_q && !dval_dly_q;
        res_data_d  = res_valid_d ? dout_q : res_data_q;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            din_q       <= '0;
            sample_q    <= 1'b0;
            btns_q      <= '0;
            dval_q      <= 1'b0;
            dval_dly_q  <= 1'b0;
            dout_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            sample_q    <= sample_d;
            btns_q      <= btns_d;
            dval_q      <= dval_d;
            dval_dly_q  <= dval_dly_d;
            dout_q      <= dout_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign cmd_ready = !fifo_full && !rst_int;
    assign Din       = din_q;
    assign Sample    = sample_q;
    assign Btns      = btns_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != ST_IDLE) || (level != '0);

endmodule
